// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [1:0] INST_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/if_inst_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs for decode.
// Clear wins over push and pop; dout reads as zero while the FIFO is empty.
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear)
            r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues one memory read at a time from the current
// PC, drives the PC load enable and queues returned instructions for decode.
module if_fetch_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pc_in,
    output logic              o_pc_ena,
    input  logic              i_flush,
    output logic              o_imem_req,
    output logic [DATA_W-1:0] o_imem_addr,
    input  logic              i_imem_rvalid,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [DATA_W-1:0] o_inst_out,
    output logic [DATA_W-1:0] o_inst_pc,
    output logic              o_misalign
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t        r_state;
    logic [DATA_W-1:0]   r_req_pc;
    logic                r_misalign;

    logic [CW-1:0]       w_count;
    logic [2*DATA_W-1:0] w_dout;
    logic                w_aligned;
    logic                w_try_issue;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_clear;

    // Issuing only from IDLE with a free slot reserves room for the response.
    assign w_aligned   = (i_pc_in[1:0] & INST_ALIGN_MASK) == 2'b00;
    assign w_try_issue = !i_rst && !i_flush && (r_state == IDLE)
                         && (w_count < CW'(DEPTH)) && !r_misalign;
    assign w_issue     = w_try_issue && w_aligned;
    assign w_push      = !i_rst && !i_flush && (r_state == WAIT) && i_imem_rvalid;
    assign w_pop       = o_inst_valid && i_inst_ready;
    assign w_clear     = i_rst || i_flush;

    assign o_imem_req  = w_issue;
    assign o_imem_addr = w_issue ? i_pc_in : '0;
    assign o_pc_ena    = w_issue || (i_flush && !i_rst);
    assign o_misalign  = r_misalign;

    assign o_inst_valid = (w_count != '0);
    assign {o_inst_pc, o_inst_out} = w_dout;

    if_inst_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_din   ({r_req_pc, i_imem_rdata}),
        .o_dout  (w_dout),
        .o_count (w_count)
    );

    // A response arriving together with a flush is dropped and ends the wait.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_req_pc   <= '0;
            r_misalign <= 1'b0;
        end else if (i_flush) begin
            r_misalign <= 1'b0;
            case (r_state)
                WAIT, DRAIN: r_state <= i_imem_rvalid ? IDLE : DRAIN;
                default:     r_state <= IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_req_pc <= i_pc_in;
                        r_state  <= WAIT;
                    end else if (w_try_issue) begin
                        r_misalign <= 1'b1;
                    end
                end
                WAIT, DRAIN: begin
                    if (i_imem_rvalid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Cycle-scripted bench for if_fetch_buffer; accepted responses are queued as
// expected {pc, instruction} pairs and compared when decode sees the head.
module tb_if_fetch_buffer;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] pcIn;
    logic              pcEna;
    logic              flush;
    logic              imemReq;
    logic [DATA_W-1:0] imemAddr;
    logic              imemRvalid;
    logic [DATA_W-1:0] imemRdata;
    logic              instValid;
    logic              instReady;
    logic [DATA_W-1:0] instOut;
    logic [DATA_W-1:0] instPc;
    logic              misalign;

    int checkCount = 0;
    int errorCount = 0;
    logic [63:0] expectQ [$];

    localparam logic [31:0] D0   = 32'h2008_0005;
    localparam logic [31:0] D1   = 32'h8C09_0004;
    localparam logic [31:0] D2   = 32'hAD0A_0008;
    localparam logic [31:0] D3   = 32'h0109_5020;
    localparam logic [31:0] D4   = 32'h1000_FFFF;
    localparam logic [31:0] D5   = 32'h3C01_1234;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    if_fetch_buffer #(.DATA_W(DATA_W), .DEPTH(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc_in       (pcIn),
        .o_pc_ena      (pcEna),
        .i_flush       (flush),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_rvalid (imemRvalid),
        .i_imem_rdata  (imemRdata),
        .o_inst_valid  (instValid),
        .i_inst_ready  (instReady),
        .o_inst_out    (instOut),
        .o_inst_pc     (instPc),
        .o_misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic r, input logic f, input logic rv,
                                 input logic rdy, input logic [31:0] pc,
                                 input logic [31:0] rdata);
        rst        = r;
        flush      = f;
        imemRvalid = rv;
        instReady  = rdy;
        pcIn       = pc;
        imemRdata  = rdata;
        #1;
    endtask

    task automatic endCycle();
        @(negedge clk);
    endtask

    task automatic checkCtl(input string tag, input logic req, input logic ena,
                            input logic [31:0] addr, input logic valid);
        checkOutput({tag, ".req"},   64'(imemReq),   64'(req));
        checkOutput({tag, ".ena"},   64'(pcEna),     64'(ena));
        checkOutput({tag, ".addr"},  64'(imemAddr),  64'(addr));
        checkOutput({tag, ".valid"}, 64'(instValid), 64'(valid));
    endtask

    task automatic expectHead(input string tag, input logic doPop);
        if (expectQ.size() == 0) begin
            checkOutput({tag, ".sbEmpty"}, 64'(expectQ.size()), 64'd1);
        end else begin
            checkOutput(tag, {instPc, instOut}, expectQ[0]);
            if (doPop)
                void'(expectQ.pop_front());
        end
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset, including a flush that must be overridden.
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
        checkCtl("rst0", 0, 0, 32'h0, 0);
        checkOutput("rst0.mis",  64'(misalign), 64'd0);
        checkOutput("rst0.head", {instPc, instOut}, 64'd0);
        endCycle();
        applyStimulus(1, 1, 0, 0, 32'h0, 32'h0);
        checkCtl("rst1", 0, 0, 32'h0, 0);
        endCycle();

        // Basic fetch with 1-cycle memory, then fill the FIFO with decode stalled.
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        checkCtl("t1.issue", 1, 1, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h4, D0);
        expectQ.push_back({32'h0, D0});
        checkCtl("t1.wait", 0, 0, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h4, 32'h0);
        checkCtl("t2.issue4", 1, 1, 32'h4, 1);
        expectHead("t1.head", 0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h8, D1);
        expectQ.push_back({32'h4, D1});
        checkCtl("t2.wait4", 0, 0, 32'h0, 1);
        endCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
            checkCtl("t2.full", 0, 0, 32'h0, 1);
            endCycle();
        end
        applyStimulus(0, 0, 0, 1, 32'h8, 32'h0);
        checkCtl("t2.popfull", 0, 0, 32'h0, 1);
        expectHead("t2.pop0", 1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
        checkCtl("t2.issue8", 1, 1, 32'h8, 1);
        expectHead("t2.head4", 0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'hC, D2);
        expectQ.push_back({32'h8, D2});
        checkCtl("t2.wait8", 0, 0, 32'h0, 1);
        endCycle();
        applyStimulus(0, 0, 0, 1, 32'hC, 32'h0);
        checkCtl("t2.full3", 0, 0, 32'h0, 1);
        expectHead("t2.pop4", 1);
        endCycle();
        applyStimulus(0, 0, 0, 1, 32'hC, 32'h0);
        checkCtl("t3.issueC", 1, 1, 32'hC, 1);
        expectHead("t2.pop8", 1);
        endCycle();

        // Flush in WAIT on a 3-cycle memory: the late response must be dropped.
        applyStimulus(0, 1, 0, 0, 32'h100, 32'h0);
        checkCtl("t3.flush", 0, 1, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h100, 32'h0);
        checkCtl("t3.drain", 0, 0, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h100, JUNK);
        checkCtl("t3.late", 0, 0, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h100, 32'h0);
        checkCtl("t3.reissue", 1, 1, 32'h100, 0);
        endCycle();

        // Flush coinciding with the response.
        applyStimulus(0, 1, 1, 0, 32'h200, JUNK);
        checkCtl("t4.flushrv", 0, 1, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h200, 32'h0);
        checkCtl("t4.issue", 1, 1, 32'h200, 0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h204, D3);
        expectQ.push_back({32'h200, D3});
        checkCtl("t4.wait", 0, 0, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 1, 32'h204, 32'h0);
        checkCtl("t4.issue2", 1, 1, 32'h204, 1);
        expectHead("t4.pop200", 1);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h208, D4);
        expectQ.push_back({32'h204, D4});
        checkCtl("t4.wait2", 0, 0, 32'h0, 0);
        endCycle();

        // Misaligned PC sets a sticky fault until flush.
        applyStimulus(0, 0, 0, 1, 32'h6, 32'h0);
        checkCtl("t5.mis", 0, 0, 32'h0, 1);
        checkOutput("t5.mis0", 64'(misalign), 64'd0);
        expectHead("t4.pop204", 1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h6, 32'h0);
        checkCtl("t5.held", 0, 0, 32'h0, 0);
        checkOutput("t5.mis1", 64'(misalign), 64'd1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
        checkCtl("t5.sticky", 0, 0, 32'h0, 0);
        checkOutput("t5.mis2", 64'(misalign), 64'd1);
        endCycle();
        applyStimulus(0, 1, 0, 0, 32'h8, 32'h0);
        checkCtl("t5.flush", 0, 1, 32'h0, 0);
        checkOutput("t5.mis3", 64'(misalign), 64'd1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
        checkCtl("t5.issue", 1, 1, 32'h8, 0);
        checkOutput("t5.misClr", 64'(misalign), 64'd0);
        endCycle();

        // Reset in WAIT, then a late response that must be ignored.
        applyStimulus(1, 0, 0, 0, 32'h40, 32'h0);
        checkCtl("t6.rst", 0, 0, 32'h0, 0);
        checkOutput("t6.mis", 64'(misalign), 64'd0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h40, JUNK);
        checkCtl("t6.late", 1, 1, 32'h40, 0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 32'h44, 32'h0);
        checkCtl("t6.nopush", 0, 0, 32'h0, 0);
        checkOutput("t6.head", {instPc, instOut}, 64'd0);
        endCycle();
        applyStimulus(0, 0, 1, 0, 32'h44, D5);
        expectQ.push_back({32'h40, D5});
        checkCtl("t6.wait", 0, 0, 32'h0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 1, 32'h44, 32'h0);
        checkCtl("t6.issue", 1, 1, 32'h44, 1);
        expectHead("t6.pop40", 1);
        endCycle();

        checkOutput("sb.drained", 64'(expectQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
